// File: rtl/spi_display_pkg.sv
// ============================================================================
//  Module      : spi_display_pkg
//  Description : Display serial-link command codes, decoder states and the
//                RGB565 pixel type. Shared by the transmit and receive sides.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_display_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CASET = 2'd1,
        S_PASET = 2'd2,
        S_RAMWR = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

`default_nettype wire

// File: rtl/spi_display_rx_if.sv
// ============================================================================
//  Module      : spi_display_rx_if
//  Description : Serial link inputs and decoded command/pixel outputs of the
//                display receiver.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface spi_display_rx_if;
    logic        i_mosi;
    logic        i_dc;
    logic        i_cs;
    logic        o_cmd_valid;
    logic [7:0]  o_cmd;
    logic        o_px_valid;
    logic [8:0]  o_px_x;
    logic [8:0]  o_px_y;
    logic [15:0] o_px_color;
    logic        o_oob;
    logic [8:0]  o_xs;
    logic [8:0]  o_xe;
    logic [8:0]  o_ys;
    logic [8:0]  o_ye;

    modport master (
        output i_mosi, i_dc, i_cs,
        input  o_cmd_valid, o_cmd, o_px_valid, o_px_x, o_px_y, o_px_color,
               o_oob, o_xs, o_xe, o_ys, o_ye
    );

    modport slave (
        input  i_mosi, i_dc, i_cs,
        output o_cmd_valid, o_cmd, o_px_valid, o_px_x, o_px_y, o_px_color,
               o_oob, o_xs, o_xe, o_ys, o_ye
    );
endinterface

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// ============================================================================
//  Module      : spi_byte_rx
//  Description : MSB-first byte deserialiser; one bit per clock while CS low.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_byte_rx (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    input  wire logic       i_mosi,
    input  wire logic       i_dc,
    input  wire logic       i_cs,
    output logic [7:0]      o_byte,
    output logic            o_dc,
    output logic            o_byte_valid
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (i_cs) begin
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
        end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[5:0], i_mosi};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // The completed byte is presented in the same cycle as its last bit so
    // the decoder can register the result on that edge.
    assign o_byte       = {shift_q, i_mosi};
    assign o_dc         = i_dc;
    assign o_byte_valid = !i_cs && (bit_cnt_q == 3'd7);

endmodule

`default_nettype wire

// File: rtl/spi_display_rx.sv
// ============================================================================
//  Module      : spi_display_rx
//  Description : Display write-interface receiver: decodes CASET/PASET/RAMWR
//                and emits one pixel write per RGB565 word.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_display_rx
    import spi_display_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    spi_display_rx_if.slave    bus
);

    localparam logic [8:0] X_LIM  = 9'(WIDTH);
    localparam logic [8:0] Y_LIM  = 9'(HEIGHT);
    localparam logic [8:0] XE_RST = 9'(WIDTH - 1);
    localparam logic [8:0] YE_RST = 9'(HEIGHT - 1);

    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       rx_valid;

    spi_byte_rx u_byte_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mosi       (bus.i_mosi),
        .i_dc         (bus.i_dc),
        .i_cs         (bus.i_cs),
        .o_byte       (rx_byte),
        .o_dc         (rx_dc),
        .o_byte_valid (rx_valid)
    );

    dec_state_e state_q, state_d;
    logic [1:0] pidx_q, pidx_d;
    logic [23:0] param_q, param_d;
    logic [8:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [8:0] x_q, x_d, y_q, y_d;
    logic       half_q, half_d;
    logic [7:0] first_q, first_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_q, cmd_d;
    logic       px_valid_q, px_valid_d;
    logic       oob_q, oob_d;
    logic [8:0] px_x_q, px_x_d, px_y_q, px_y_d;
    rgb565_t    px_color_q, px_color_d;
    logic [8:0] win_start, win_end;

    // Parameter values are 16-bit on the wire; only the low 9 bits are kept.
    assign win_start = {param_q[16], param_q[15:8]};
    assign win_end   = {param_q[0], rx_byte};

    always_comb begin
        state_d     = state_q;
        pidx_d      = pidx_q;
        param_d     = param_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        x_d         = x_q;
        y_d         = y_q;
        half_d      = half_q;
        first_d     = first_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        px_valid_d  = 1'b0;
        oob_d       = 1'b0;
        px_x_d      = px_x_q;
        px_y_d      = px_y_q;
        px_color_d  = px_color_q;
        if (rx_valid && !rx_dc) begin
            cmd_valid_d = 1'b1;
            cmd_d       = rx_byte;
            pidx_d      = 2'd0;
            case (rx_byte)
                CMD_CASET: state_d = S_CASET;
                CMD_PASET: state_d = S_PASET;
                CMD_RAMWR: begin
                    state_d = S_RAMWR;
                    x_d     = xs_q;
                    y_d     = ys_q;
                    half_d  = 1'b0;
                end
                default:   state_d = S_IDLE;
            endcase
        end else if (rx_valid) begin
            case (state_q)
                S_CASET, S_PASET: begin
                    case (pidx_q)
                        2'd0:    param_d[23:16] = rx_byte;
                        2'd1:    param_d[15:8]  = rx_byte;
                        2'd2:    param_d[7:0]   = rx_byte;
                        default: param_d        = param_q;
                    endcase
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) begin
                        if (state_q == S_CASET) begin
                            xs_d = win_start;
                            xe_d = win_end;
                        end else begin
                            ys_d = win_start;
                            ye_d = win_end;
                        end
                        state_d = S_IDLE;
                    end
                end
                S_RAMWR: begin
                    if (!half_q) begin
                        first_d = rx_byte;
                        half_d  = 1'b1;
                    end else begin
                        half_d     = 1'b0;
                        px_x_d     = x_q;
                        px_y_d     = y_q;
                        px_color_d = rgb565_t'({first_q, rx_byte});
                        if (x_q < X_LIM && y_q < Y_LIM) px_valid_d = 1'b1;
                        else                            oob_d      = 1'b1;
                        // Cursor wraps on equality with the end value only,
                        // so an inverted window runs until 9-bit overflow.
                        if (x_q == xe_q) begin
                            x_d = xs_q;
                            y_d = (y_q == ye_q) ? ys_q : y_q + 9'd1;
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            pidx_q      <= 2'd0;
            param_q     <= 24'd0;
            xs_q        <= 9'd0;
            xe_q        <= XE_RST;
            ys_q        <= 9'd0;
            ye_q        <= YE_RST;
            x_q         <= 9'd0;
            y_q         <= 9'd0;
            half_q      <= 1'b0;
            first_q     <= 8'd0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 8'd0;
            px_valid_q  <= 1'b0;
            oob_q       <= 1'b0;
            px_x_q      <= 9'd0;
            px_y_q      <= 9'd0;
            px_color_q  <= '0;
        end else begin
            state_q     <= state_d;
            pidx_q      <= pidx_d;
            param_q     <= param_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            x_q         <= x_d;
            y_q         <= y_d;
            half_q      <= half_d;
            first_q     <= first_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            px_valid_q  <= px_valid_d;
            oob_q       <= oob_d;
            px_x_q      <= px_x_d;
            px_y_q      <= px_y_d;
            px_color_q  <= px_color_d;
        end
    end

    assign bus.o_cmd_valid = cmd_valid_q;
    assign bus.o_cmd       = cmd_q;
    assign bus.o_px_valid  = px_valid_q;
    assign bus.o_px_x      = px_x_q;
    assign bus.o_px_y      = px_y_q;
    assign bus.o_px_color  = px_color_q;
    assign bus.o_oob       = oob_q;
    assign bus.o_xs        = xs_q;
    assign bus.o_xe        = xe_q;
    assign bus.o_ys        = ys_q;
    assign bus.o_ye        = ye_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_display_rx.sv
// ============================================================================
//  Module      : tb_spi_display_rx
//  Description : Directed byte-vector bench for the display receiver.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_display_rx;

    localparam int K_NONE = 0;
    localparam int K_CMD  = 1;
    localparam int K_PX   = 2;
    localparam int K_OOB  = 3;

    typedef struct {
        logic        dc;
        logic [7:0]  data;
        int          kind;
        logic [8:0]  ex;
        logic [8:0]  ey;
        logic [15:0] ecol;
        logic        chk_win;
        logic [8:0]  wxs, wxe, wys, wye;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_px = 0, n_cmd = 0, n_oob = 0;
    vec_t vecs[$];

    spi_display_rx_if bus ();

    spi_display_rx #(.WIDTH(240), .HEIGHT(320)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_px_valid)  n_px++;
        if (bus.o_cmd_valid) n_cmd++;
        if (bus.o_oob)       n_oob++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.i_mosi = b[7 - i];
            bus.i_dc   = dc;
            bus.i_cs   = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cs_idle(input int n);
        bus.i_cs = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_win(input string tag, input logic [8:0] xs, xe, ys, ye);
        chk({tag, "_xs"}, 32'(bus.o_xs), 32'(xs));
        chk({tag, "_xe"}, 32'(bus.o_xe), 32'(xe));
        chk({tag, "_ys"}, 32'(bus.o_ys), 32'(ys));
        chk({tag, "_ye"}, 32'(bus.o_ye), 32'(ye));
    endtask

    function automatic vec_t mk(input logic dc, input logic [7:0] d, input int k,
                                input logic [8:0] x, input logic [8:0] y,
                                input logic [15:0] c);
        vec_t v;
        v.dc = dc; v.data = d; v.kind = k; v.ex = x; v.ey = y; v.ecol = c;
        v.chk_win = 1'b0; v.wxs = '0; v.wxe = '0; v.wys = '0; v.wye = '0;
        return v;
    endfunction

    function automatic vec_t mkw(input logic [7:0] d, input logic [8:0] xs, xe, ys, ye);
        vec_t v;
        v = mk(1'b1, d, K_NONE, 9'd0, 9'd0, 16'd0);
        v.chk_win = 1'b1; v.wxs = xs; v.wxe = xe; v.wys = ys; v.wye = ye;
        return v;
    endfunction

    function automatic vec_t cmd(input logic [7:0] d);
        return mk(1'b0, d, K_CMD, 9'd0, 9'd0, 16'd0);
    endfunction

    function automatic vec_t dat(input logic [7:0] d);
        return mk(1'b1, d, K_NONE, 9'd0, 9'd0, 16'd0);
    endfunction

    initial begin
        int px0, cmd0;
        // Window 15..55 x 122..245 and two pixels at its origin
        vecs.push_back(cmd(8'h2A));
        vecs.push_back(dat(8'h00)); vecs.push_back(dat(8'h0F)); vecs.push_back(dat(8'h00));
        vecs.push_back(mkw(8'h37, 9'd15, 9'd55, 9'd0, 9'd319));
        vecs.push_back(cmd(8'h2B));
        vecs.push_back(dat(8'h00)); vecs.push_back(dat(8'h7A)); vecs.push_back(dat(8'h00));
        vecs.push_back(mkw(8'hF5, 9'd15, 9'd55, 9'd122, 9'd245));
        vecs.push_back(cmd(8'h2C));
        vecs.push_back(dat(8'hF8));
        vecs.push_back(mk(1'b1, 8'h00, K_PX, 9'd15, 9'd122, 16'hF800));
        vecs.push_back(dat(8'h07));
        vecs.push_back(mk(1'b1, 8'hE0, K_PX, 9'd16, 9'd122, 16'h07E0));
        // One-column window: column wrap then frame wrap
        vecs.push_back(cmd(8'h2A));
        vecs.push_back(dat(8'h00)); vecs.push_back(dat(8'h37)); vecs.push_back(dat(8'h00));
        vecs.push_back(mkw(8'h37, 9'd55, 9'd55, 9'd122, 9'd245));
        vecs.push_back(cmd(8'h2B));
        vecs.push_back(dat(8'h00)); vecs.push_back(dat(8'h7A)); vecs.push_back(dat(8'h00));
        vecs.push_back(mkw(8'h7B, 9'd55, 9'd55, 9'd122, 9'd123));
        vecs.push_back(cmd(8'h2C));
        vecs.push_back(dat(8'hAA));
        vecs.push_back(mk(1'b1, 8'hBB, K_PX, 9'd55, 9'd122, 16'hAABB));
        vecs.push_back(dat(8'h12));
        vecs.push_back(mk(1'b1, 8'h34, K_PX, 9'd55, 9'd123, 16'h1234));
        vecs.push_back(dat(8'h56));
        vecs.push_back(mk(1'b1, 8'h78, K_PX, 9'd55, 9'd122, 16'h5678));
        // Right edge: x = 239 in range, x = 240 out of range
        vecs.push_back(cmd(8'h2A));
        vecs.push_back(dat(8'h00)); vecs.push_back(dat(8'hEF)); vecs.push_back(dat(8'h00));
        vecs.push_back(mkw(8'hF0, 9'd239, 9'd240, 9'd122, 9'd123));
        vecs.push_back(cmd(8'h2C));
        vecs.push_back(dat(8'h11));
        vecs.push_back(mk(1'b1, 8'h22, K_PX, 9'd239, 9'd122, 16'h1122));
        vecs.push_back(dat(8'h33));
        vecs.push_back(mk(1'b1, 8'h44, K_OOB, 9'd0, 9'd0, 16'd0));

        bus.i_mosi = 1'b0;
        bus.i_dc   = 1'b0;
        bus.i_cs   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state with CS idle
        cs_idle(100);
        chk("rst_cmd_valid", 32'(bus.o_cmd_valid), 32'd0);
        chk("rst_cmd", 32'(bus.o_cmd), 32'd0);
        chk("rst_px_x", 32'(bus.o_px_x), 32'd0);
        chk("rst_px_y", 32'(bus.o_px_y), 32'd0);
        chk("rst_px_color", 32'(bus.o_px_color), 32'd0);
        chk_win("rst", 9'd0, 9'd239, 9'd0, 9'd319);
        chk("rst_no_pulses", 32'(n_px + n_cmd + n_oob), 32'd0);

        // Byte vectors, each checked one cycle after its final bit
        foreach (vecs[i]) begin
            send_bits(vecs[i].data, vecs[i].dc, 8);
            chk($sformatf("v%0d_cmd_valid", i), 32'(bus.o_cmd_valid), 32'(vecs[i].kind == K_CMD));
            chk($sformatf("v%0d_px_valid", i), 32'(bus.o_px_valid), 32'(vecs[i].kind == K_PX));
            chk($sformatf("v%0d_oob", i), 32'(bus.o_oob), 32'(vecs[i].kind == K_OOB));
            if (vecs[i].kind == K_CMD)
                chk($sformatf("v%0d_cmd", i), 32'(bus.o_cmd), 32'(vecs[i].data));
            if (vecs[i].kind == K_PX) begin
                chk($sformatf("v%0d_px_x", i), 32'(bus.o_px_x), 32'(vecs[i].ex));
                chk($sformatf("v%0d_px_y", i), 32'(bus.o_px_y), 32'(vecs[i].ey));
                chk($sformatf("v%0d_px_color", i), 32'(bus.o_px_color), 32'(vecs[i].ecol));
            end
            if (vecs[i].chk_win)
                chk_win($sformatf("v%0d", i), vecs[i].wxs, vecs[i].wxe, vecs[i].wys, vecs[i].wye);
        end
        cs_idle(2);
        chk("tbl_px_total", 32'(n_px), 32'd6);
        chk("tbl_cmd_total", 32'(n_cmd), 32'd8);
        chk("tbl_oob_total", 32'(n_oob), 32'd1);

        // Partial byte (5 bits), then CS rising on the final bit
        cmd0 = n_cmd;
        send_bits(8'h2A, 1'b0, 5);
        cs_idle(1);
        send_bits(8'h2A, 1'b0, 7);
        bus.i_mosi = 1'b0;
        cs_idle(3);
        chk("partial_no_cmd", 32'(n_cmd), 32'(cmd0));
        send_bits(8'h2A, 1'b0, 8);
        chk("partial_cmd", 32'(bus.o_cmd), 32'h2A);
        send_bits(8'h00, 1'b1, 8);
        send_bits(8'h01, 1'b1, 8);
        send_bits(8'h00, 1'b1, 8);
        send_bits(8'h02, 1'b1, 8);
        chk_win("partial", 9'd1, 9'd2, 9'd122, 9'd123);
        cs_idle(2);
        chk("partial_one_cmd", 32'(n_cmd), 32'(cmd0 + 1));

        // Reset in the middle of a pixel word
        send_bits(8'h2C, 1'b0, 8);
        send_bits(8'hF0, 1'b1, 8);
        bus.i_cs = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mid_rst_cmd", 32'(bus.o_cmd), 32'd0);
        chk("mid_rst_px_color", 32'(bus.o_px_color), 32'd0);
        chk_win("mid_rst", 9'd0, 9'd239, 9'd0, 9'd319);
        px0 = n_px;
        send_bits(8'h0F, 1'b1, 8);
        send_bits(8'hAB, 1'b1, 8);
        send_bits(8'hCD, 1'b1, 8);
        send_bits(8'hEF, 1'b1, 8);
        cs_idle(2);
        chk("mid_rst_no_px", 32'(n_px), 32'(px0));
        send_bits(8'h2C, 1'b0, 8);
        send_bits(8'h12, 1'b1, 8);
        send_bits(8'h34, 1'b1, 8);
        chk("post_rst_px_valid", 32'(bus.o_px_valid), 32'd1);
        chk("post_rst_px_x", 32'(bus.o_px_x), 32'd0);
        chk("post_rst_px_y", 32'(bus.o_px_y), 32'd0);
        chk("post_rst_px_color", 32'(bus.o_px_color), 32'h1234);
        cs_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
